// File: rtl/axis_pixel_packer.sv
// axis_pixel_packer: packs one-pixel AXI-Stream beats into PIXELS_PER_BEAT-pixel beats with tlast flush and tkeep mask
module axis_pixel_packer #(
    parameter int PIXEL_WIDTH     = 24,
    parameter int PIXELS_PER_BEAT = 4
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    input  logic [PIXEL_WIDTH-1:0]                   s_axis_tdata,
    input  logic                                     s_axis_tlast,
    input  logic                                     s_axis_tuser,
    output logic                                     m_axis_tvalid,
    input  logic                                     m_axis_tready,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0]   m_axis_tdata,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT/8-1:0] m_axis_tkeep,
    output logic                                     m_axis_tlast,
    output logic                                     m_axis_tuser,
    output logic                                     frame_err
);
    localparam int OUT_WIDTH  = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int KEEP_WIDTH = OUT_WIDTH / 8;
    localparam int BPP        = PIXEL_WIDTH / 8;
    localparam int SW         = $clog2(PIXELS_PER_BEAT);
    logic [SW-1:0]         slot;
    logic [OUT_WIDTH-1:0]  acc;
    logic                  acc_user;
    logic                  accept;
    logic                  done;
    logic [OUT_WIDTH-1:0]  merged;
    logic [KEEP_WIDTH-1:0] keep;
    assign s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign done          = s_axis_tlast || slot == SW'(PIXELS_PER_BEAT - 1);
    // slots above the current one are still zero because the accumulator is cleared on every completion
    assign merged        = acc | (OUT_WIDTH'(s_axis_tdata) << (int'(slot) * PIXEL_WIDTH));
    assign keep          = {KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH - (int'(slot) + 1) * BPP);
    always_ff @(posedge aclk) begin
        if (areset) begin
            slot          <= '0;
            acc           <= '0;
            acc_user      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            if (m_axis_tready)
                m_axis_tvalid <= 1'b0;
            if (accept) begin
                if (s_axis_tuser && slot != '0)
                    frame_err <= 1'b1;
                if (done) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= merged;
                    m_axis_tkeep  <= keep;
                    m_axis_tlast  <= s_axis_tlast;
                    m_axis_tuser  <= acc_user | s_axis_tuser;
                    acc           <= '0;
                    acc_user      <= 1'b0;
                    slot          <= '0;
                end else begin
                    acc           <= merged;
                    acc_user      <= acc_user | s_axis_tuser;
                    slot          <= slot + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_pixel_packer.sv
// tb_axis_pixel_packer: randomized scoreboard bench with a pixel-list reference model
module tb_axis_pixel_packer;
    localparam int PW = 24;
    localparam int PPB = 4;
    localparam int OW = PW * PPB;
    localparam int KW = OW / 8;
    typedef struct {
        logic [OW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic          u;
    } beat_t;
    typedef struct {
        logic [PW-1:0] d;
        logic          u;
    } pix_t;
    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [PW-1:0] s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic [OW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          frame_err;
    int            checks = 0;
    int            failures = 0;
    int            n_acc = 0;
    bit            rnd_mode = 0;
    beat_t         exp_q[$];
    pix_t          pend[$];
    logic          exp_ferr = 1'b0;
    logic          rst_prev = 1'b0;
    logic          hold_prev = 1'b0;
    logic [OW+KW+1:0] prev_beat = '0;
    axis_pixel_packer #(.PIXEL_WIDTH(PW), .PIXELS_PER_BEAT(PPB)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .frame_err(frame_err)
    );
    always #5 aclk = ~aclk;
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic beat_t build(input logic last);
        beat_t b;
        b.d = '0;
        b.u = 1'b0;
        foreach (pend[i]) begin
            b.d = b.d | (OW'(pend[i].d) << (PW * i));
            b.u = b.u | pend[i].u;
        end
        b.k = KW'((1 << (pend.size() * (PW / 8))) - 1);
        b.l = last;
        return b;
    endfunction
    // monitor and reference model: outputs are compared before this cycle's accepted pixel is modelled
    always @(negedge aclk) begin
        if (areset) begin
            if (rst_prev) begin
                chk("rst_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, frame_err}, '0);
            end
            chk("rst_ready", s_axis_tready, 0);
            exp_q.delete();
            pend.delete();
            exp_ferr = 1'b0;
            hold_prev = 1'b0;
        end else begin
            chk("m_valid", m_axis_tvalid, exp_q.size() != 0);
            chk("s_ready", s_axis_tready, exp_q.size() == 0 || m_axis_tready);
            chk("frame_err", frame_err, exp_ferr);
            if (hold_prev)
                chk("hold_stable", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, prev_beat);
            hold_prev = m_axis_tvalid && !m_axis_tready;
            prev_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
                beat_t b;
                b = exp_q.pop_front();
                chk("beat_data", m_axis_tdata, b.d);
                chk("beat_keep", m_axis_tkeep, b.k);
                chk("beat_last", m_axis_tlast, b.l);
                chk("beat_user", m_axis_tuser, b.u);
            end
            if (s_axis_tvalid && s_axis_tready) begin
                pix_t p;
                n_acc++;
                if (s_axis_tuser && pend.size() != 0)
                    exp_ferr = 1'b1;
                p.d = s_axis_tdata;
                p.u = s_axis_tuser;
                pend.push_back(p);
                if (s_axis_tlast || pend.size() == PPB) begin
                    exp_q.push_back(build(s_axis_tlast));
                    pend.delete();
                end
            end
        end
        rst_prev = areset;
    end
    task automatic send(input logic [PW-1:0] d, input logic last, input logic user);
        bit ok = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge aclk);
            ok = s_axis_tready;
        end
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got=no_accept expected=accept at %0t", $time);
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask
    task automatic cycles(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask
    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (rnd_mode)
                m_axis_tready = ($urandom_range(0, 9) < 7);
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int acc0;
        logic [PW-1:0] p;
        cycles(3);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        cycles(2);
        for (int i = 1; i <= 8; i++) send(PW'(i), i == 8, i == 1);
        for (int i = 1; i <= 6; i++) send(PW'('hA0 + i), i == 6, 1'b0);
        send(PW'('hB1), 1'b0, 1'b0);
        send(PW'('hB2), 1'b0, 1'b0);
        send(PW'('hB3), 1'b0, 1'b1);
        send(PW'('hB4), 1'b1, 1'b0);
        send(PW'('hC1), 1'b1, 1'b0);
        cycles(3);
        m_axis_tready = 1'b0;
        acc0 = n_acc;
        p = PW'('h100);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = p;
        for (int i = 0; i < 10; i++) begin
            bit took;
            @(negedge aclk);
            took = s_axis_tready;
            @(posedge aclk);
            #1;
            if (took) begin
                p++;
                s_axis_tdata = p;
            end
        end
        chk("stall_accepts", n_acc - acc0, 4);
        chk("stall_ready_low", s_axis_tready, 0);
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b0;
        for (int i = 0; i < 4; i++) send(p + PW'(i), i == 3, 1'b0);
        send(PW'('hD1), 1'b0, 1'b0);
        send(PW'('hD2), 1'b0, 1'b0);
        areset = 1'b1;
        cycles(2);
        areset = 1'b0;
        for (int i = 1; i <= 4; i++) send(PW'('hE0 + i), i == 4, 1'b0);
        rnd_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            send(PW'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
        send(PW'($urandom), 1'b1, 1'b0);
        rnd_mode = 0;
        #1;
        m_axis_tready = 1'b1;
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) cycles(1);
        chk("drain_empty", exp_q.size(), 0);
        cycles(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axis_pixel_packer.md
# axis_pixel_packer

Parametrised AXI-Stream pixel packer for the super-resolution datapath. It accepts one pixel per beat on a narrow slave stream and emits PIXELS_PER_BEAT pixels per beat on a wide master stream. A line-end (tlast) flushes a partial beat with a correct tkeep mask. It sits between the pixel-rate upscaling core and the wide memory-write / DMA path, and replaces the fixed 24-bit, one-pixel-per-beat stream link.

## Interface
Parameters:
- PIXEL_WIDTH, 24, bits per pixel; must be a multiple of 8.
- PIXELS_PER_BEAT, 4, pixels packed per output beat; must be at least 2.
- Derived: OUT_WIDTH = PIXEL_WIDTH*PIXELS_PER_BEAT; KEEP_WIDTH = OUT_WIDTH/8; BPP = PIXEL_WIDTH/8.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  input pixel valid.
- s_axis_tready  out  1  packer can accept a pixel.
- s_axis_tdata  in  PIXEL_WIDTH  pixel.
- s_axis_tlast  in  1  last pixel of line.
- s_axis_tuser  in  1  start of frame.
- m_axis_tvalid  out  1  packed beat valid.
- m_axis_tready  in  1  downstream accepts the beat.
- m_axis_tdata  out  OUT_WIDTH  packed pixels; slot i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
- m_axis_tkeep  out  KEEP_WIDTH  byte-valid mask.
- m_axis_tlast  out  1  beat ends a line.
- m_axis_tuser  out  1  beat carries the start-of-frame pixel.
- frame_err  out  1  sticky; s_axis_tuser seen at a non-zero slot.

## Operation
- Pixel handshake: a pixel transfers when s_axis_tvalid and s_axis_tready are both high.
- Internal state: slot counter (0 to PIXELS_PER_BEAT-1), accumulator (data, tuser flag), and a one-beat output register.
- Each accepted pixel is written into accumulator slot `slot`.
- A pixel completes a beat if `slot` equals PIXELS_PER_BEAT-1 or s_axis_tlast is high. On completion:
  - The accumulator, including the current pixel, loads the output register.
  - Slots above the current one are zero in tdata.
  - tkeep = low (slot+1)*BPP bits set; all other bits clear.
  - tlast = s_axis_tlast.
  - tuser = accumulated tuser OR current tuser.
  - The accumulator is cleared and slot returns to 0.
- A non-completing pixel increments slot and ORs its tuser into the accumulator flag.
- s_axis_tready = !areset && (!m_axis_tvalid || m_axis_tready). It is registered-state-based and does not depend on s_axis_tvalid, tdata or tlast.
- The output register holds tdata, tkeep, tlast and tuser stable while m_axis_tvalid && !m_axis_tready.
- m_axis_tvalid clears on an accepted beat unless a new completion loads in the same cycle.
- Simultaneous case (m_axis_tready accepts the held beat while a completing pixel arrives): the new beat loads and m_axis_tvalid stays high, with no bubble.
- frame_err: set when an accepted pixel has s_axis_tuser=1 and slot≠0. The pixel is still packed normally. frame_err clears only on reset.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, m_axis_tuser=0, frame_err=0, s_axis_tready=0, slot=0, accumulator=0.
- Reset mid-operation: the partial accumulator and any pending output beat are discarded, and no beat is emitted. The first pixel after reset goes to slot 0.
- Latency: a completing pixel accepted at edge N gives m_axis_tvalid high after edge N (visible in cycle N+1).
- Throughput: one pixel per cycle is sustained while m_axis_tready is high. The output is valid at most one cycle in every PIXELS_PER_BEAT for full lines.
- Backpressure: while the output register is full and m_axis_tready is low, s_axis_tready is low and no pixel is accepted, including non-completing ones.
- Line length not a multiple of PIXELS_PER_BEAT: the final beat is partial with tlast=1, and the next line starts at slot 0.
- Single-pixel line (tlast at slot 0): a beat with tkeep = BPP low bits set.

## Test plan
With PIXEL_WIDTH=24 and PIXELS_PER_BEAT=4:
- Reset then idle -> all outputs 0 during reset; s_axis_tready=1 on the first cycle after areset falls.
- 8 pixels 0x000001..0x000008, tlast on the 8th, m_axis_tready=1 -> two beats: 0x000004_000003_000002_000001 with tkeep=0xFFF and tlast=0, then 0x000008_000007_000006_000005 with tkeep=0xFFF and tlast=1; each beat appears 1 cycle after its 4th pixel.
- 6-pixel line 0xA1..0xA6 with tlast on 0xA6 -> second beat tdata upper 48 bits zero, tkeep=0x03F, tlast=1; the next line begins at slot 0.
- tuser on pixel 0 of a frame -> first beat m_axis_tuser=1 and all later beats 0. tuser on the 3rd pixel of a beat -> that beat tuser=1 and frame_err=1, which stays high until reset.
- Hold m_axis_tready=0 for 10 cycles with a continuous input -> exactly 4 pixels accepted, beat data stable, s_axis_tready=0 afterwards. When m_axis_tready returns, the accept and the next completion run back-to-back with no bubble and no lost or duplicated pixel.
- Assert areset after 2 pixels of a beat -> no beat emitted. After release, 4 new pixels produce one beat containing only the new pixels with tkeep=0xFFF.
